// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: boot sequencer for the CPU.
//   Assembles UART bytes into little-endian 32-bit words and writes them to
//   program memory. It stops at the SENTINEL word and then releases the core.
//   It also tracks run completion and reload, and latches a sticky error on
//   overflow, inter-byte timeout or an empty program.
// Optional feature macro: PROG_LOAD_CHECKSUM_EN. When defined, a 4-byte
//   checksum word must follow the sentinel. It must equal the mod-2^32 sum of
//   all written words.
// Ports:
//   clk, reset_n (async, active low)
//   rx_valid/rx_data            : one-cycle UART byte strobe + byte
//   run_finished                : core end-of-program level (rising edge used)
//   fetch_enable, run_flag      : core release (RUN only)
//   program_mem_write_enable/_data, uart_write_address : memory write port
//   load_word_count             : words written by the last completed load
//   load_error                  : sticky error
//   state_o                     : FSM state (IDLE=0 LOAD=1 RUN=2 DONE=3 ERROR=4)
module prog_load_ctrl #(
  parameter int          MEM_WORDS      = 256,
  parameter logic [31:0] SENTINEL       = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         run_finished,
  output logic                         fetch_enable,
  output logic                         run_flag,
  output logic                         program_mem_write_enable,
  output logic [31:0]                  program_mem_write_data,
  output logic [31:0]                  uart_write_address,
  output logic [$clog2(MEM_WORDS):0]   load_word_count,
  output logic                         load_error,
  output logic [2:0]                   state_o
);
  localparam int IW = $clog2(MEM_WORDS) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] FULL_IDX = IW'(MEM_WORDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_DONE = 3'd3, S_ERROR = 3'd4
  } state_t;

  state_t        r_state;
  logic [1:0]    r_byte_idx;
  logic [IW-1:0] r_word_idx;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_word;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [31:0]   r_waddr;
  logic [IW-1:0] r_cnt;
  logic          r_err;
  logic          r_run;
  logic          r_fetch;
  logic          r_rf_d;
`ifdef PROG_LOAD_CHECKSUM_EN
  logic          r_ck_phase;  // sentinel seen, collecting checksum bytes
  logic [31:0]   r_sum;
`endif

  // Complete word as it stands when the 4th byte arrives.
  logic [31:0] w_word;
  assign w_word = {rx_data, r_word[23:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_tcnt     <= '0;
      r_word     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_waddr    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_run      <= 1'b0;
      r_fetch    <= 1'b0;
      r_rf_d     <= 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
      r_ck_phase <= 1'b0;
      r_sum      <= '0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_rf_d <= run_finished;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (rx_valid) begin
            r_word     <= {24'd0, rx_data};
            r_byte_idx <= 2'd1;
            r_word_idx <= '0;
            r_tcnt     <= '0;
            r_state    <= S_LOAD;
`ifdef PROG_LOAD_CHECKSUM_EN
            r_ck_phase <= 1'b0;
            r_sum      <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (rx_valid) begin
            r_tcnt                    <= '0;
            r_word[8*r_byte_idx +: 8] <= rx_data;
            r_byte_idx                <= r_byte_idx + 2'd1;  // wraps to 0 after lane 3
            if (r_byte_idx == 2'd3) begin
`ifdef PROG_LOAD_CHECKSUM_EN
              if (r_ck_phase) begin
                if (w_word == r_sum) begin
                  r_cnt   <= r_word_idx;
                  r_run   <= 1'b1;
                  r_fetch <= 1'b1;
                  r_state <= S_RUN;
                end else begin
                  r_err   <= 1'b1;
                  r_state <= S_ERROR;
                end
              end else
`endif
              if (w_word == SENTINEL) begin
                if (r_word_idx == '0) begin
                  r_err   <= 1'b1;
                  r_state <= S_ERROR;
                end else begin
`ifdef PROG_LOAD_CHECKSUM_EN
                  r_ck_phase <= 1'b1;
`else
                  r_cnt   <= r_word_idx;
                  r_run   <= 1'b1;
                  r_fetch <= 1'b1;
                  r_state <= S_RUN;
`endif
                end
              end else if (r_word_idx == FULL_IDX) begin
                r_err   <= 1'b1;
                r_state <= S_ERROR;
              end else begin
                r_we       <= 1'b1;
                r_wdata    <= w_word;
                r_waddr    <= 32'({r_word_idx, 2'b00});
                r_word_idx <= r_word_idx + IW'(1);
`ifdef PROG_LOAD_CHECKSUM_EN
                r_sum      <= r_sum + w_word;
`endif
              end
            end
          end else if (r_byte_idx != 2'd0) begin
            // Only a partially received word can time out.
            if (r_tcnt == TMO_LAST) begin
              r_byte_idx <= '0;
              r_err      <= 1'b1;
              r_state    <= S_ERROR;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        S_RUN: begin
          if (run_finished && !r_rf_d) begin
            r_run   <= 1'b0;
            r_fetch <= 1'b0;
            r_wdata <= '0;
            r_waddr <= '0;
            r_state <= S_DONE;
          end
        end
        S_ERROR: begin
          r_err   <= 1'b1;
          r_run   <= 1'b0;
          r_fetch <= 1'b0;
        end
        default: begin
          r_err   <= 1'b1;
          r_state <= S_ERROR;
        end
      endcase
    end
  end

  assign fetch_enable             = r_fetch;
  assign run_flag                 = r_run;
  assign program_mem_write_enable = r_we;
  assign program_mem_write_data   = r_wdata;
  assign uart_write_address       = r_waddr;
  assign load_word_count          = r_cnt;
  assign load_error               = r_err;
  assign state_o                  = r_state;
endmodule

// File: tb/tb_prog_load_ctrl.sv
module tb_prog_load_ctrl;
  localparam int MW = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        run_finished;
  logic        fetch_enable, run_flag, we, load_error;
  logic [31:0] wdata, waddr;
  logic [$clog2(MW):0] wcnt;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];

  always #5 clk = ~clk;

  prog_load_ctrl #(.MEM_WORDS(MW), .SENTINEL(32'hFFFF_FFFF), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .run_finished(run_finished), .fetch_enable(fetch_enable), .run_flag(run_flag),
    .program_mem_write_enable(we), .program_mem_write_data(wdata),
    .uart_write_address(waddr), .load_word_count(wcnt), .load_error(load_error),
    .state_o(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard check of every write strobe.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed addr %h data %h expected no write", waddr, wdata);
      end
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("write_addr", waddr, e.a);
        chk("write_data", wdata, e.d);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_run_flag"}, 32'(run_flag), 32'd0);
    chk({tag, "_fetch"}, 32'(fetch_enable), 32'd0);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_waddr"}, waddr, 32'd0);
    chk({tag, "_count"}, 32'(wcnt), 32'd0);
    chk({tag, "_error"}, 32'(load_error), 32'd0);
  endtask

  task automatic chk_sb_empty(input string tag);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; run_finished = 1'b0;
    idle(2);
    chk_zero("reset");
    reset_n = 1'b1;
    idle(1);

    // Two words, then sentinel.
    expect_wr(32'd0, 32'h0000_0013);
    expect_wr(32'd4, 32'h0000_10B7);
    send_word(32'h0000_0013);
    send_word(32'h0000_10B7);
    chk("load_state", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    chk("run_flag_before_last_ff", 32'(run_flag), 32'd0);
    send_byte(8'hFF);
`ifndef PROG_LOAD_CHECKSUM_EN
    chk("run_flag", 32'(run_flag), 32'd1);
    chk("fetch_en", 32'(fetch_enable), 32'd1);
    chk("word_count", 32'(wcnt), 32'd2);
    chk("run_state", 32'(state), 32'd2);
    // Bytes in RUN are ignored.
    send_byte(8'h55);
    idle(2);
    chk("run_ignores_rx", 32'(state), 32'd2);
    chk_sb_empty("sb_after_load");

    // Run completion, then reload.
    run_finished = 1'b1;
    idle(1);
    chk("done_run_flag", 32'(run_flag), 32'd0);
    chk("done_fetch", 32'(fetch_enable), 32'd0);
    chk("done_state", 32'(state), 32'd3);
    chk("done_count", 32'(wcnt), 32'd2);
    run_finished = 1'b0;
    idle(2);
    expect_wr(32'd0, 32'h0010_0093);
    send_word(32'h0010_0093);
    idle(2);
    chk_sb_empty("sb_after_reload");
    chk("reload_state", 32'(state), 32'd1);

    // Timeout on a partial word.
    send_byte(8'h11);
    send_byte(8'h22);
    idle(40);
    chk("pre_timeout_state", 32'(state), 32'd1);
    idle(15);
    chk("timeout_state", 32'(state), 32'd4);
    chk("timeout_error", 32'(load_error), 32'd1);
    send_word(32'h1234_5678);
    idle(3);
    chk("error_sticky_state", 32'(state), 32'd4);
    chk("error_sticky_flag", 32'(load_error), 32'd1);
    chk("error_run_flag", 32'(run_flag), 32'd0);
`endif

    // Overflow: 4 writes fit, the 5th word errors.
    do_reset();
    chk("post_reset_state", 32'(state), 32'd0);
    for (int k = 0; k < MW; k++) expect_wr(32'(k * 4), 32'hA5A5_0000 + 32'(k));
    for (int k = 0; k < MW; k++) send_word(32'hA5A5_0000 + 32'(k));
    idle(1);
    chk("full_still_load", 32'(state), 32'd1);
    send_word(32'hA5A5_0004);
    chk("overflow_state", 32'(state), 32'd4);
    chk("overflow_error", 32'(load_error), 32'd1);
    idle(2);
    chk_sb_empty("sb_after_overflow");

    // Reset mid-load.
    do_reset();
    expect_wr(32'd0, 32'hCAFE_0001);
    send_word(32'hCAFE_0001);
    send_byte(8'h01);
    send_byte(8'h02);
    reset_n = 1'b0;
    #2;
    chk_zero("midload_reset");
    reset_n = 1'b1;
    idle(1);
    expect_wr(32'd0, 32'hBEEF_0002);
    send_word(32'hBEEF_0002);
    idle(2);
    chk_sb_empty("sb_after_midload_reset");

    // Empty program: sentinel first.
    do_reset();
    send_word(32'hFFFF_FFFF);
    chk("empty_prog_state", 32'(state), 32'd4);
    chk("empty_prog_error", 32'(load_error), 32'd1);

`ifdef PROG_LOAD_CHECKSUM_EN
    // Good checksum.
    do_reset();
    expect_wr(32'd0, 32'd1);
    expect_wr(32'd4, 32'd2);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'hFFFF_FFFF);
    chk("ck_wait_state", 32'(state), 32'd1);
    send_word(32'd3);
    chk("ck_ok_state", 32'(state), 32'd2);
    chk("ck_ok_run_flag", 32'(run_flag), 32'd1);
    chk("ck_ok_count", 32'(wcnt), 32'd2);
    // Bad checksum.
    do_reset();
    expect_wr(32'd0, 32'd1);
    expect_wr(32'd4, 32'd2);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'hFFFF_FFFF);
    send_word(32'd4);
    chk("ck_bad_state", 32'(state), 32'd4);
    chk("ck_bad_error", 32'(load_error), 32'd1);
`endif

    idle(3);
    chk_sb_empty("sb_final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
Sequences the CPU's boot. It assembles UART receive bytes into 32-bit little-endian words, writes them into program memory, detects the end-of-program sentinel, then releases the core by asserting run_flag. It owns the program-memory write port and gates fetch access: the loader has it during LOAD, fetch has it during RUN. It tracks run completion and reload, and raises a sticky error on overflow or inter-byte timeout.

Parameters:
MEM_WORDS, 256, program memory depth in 32-bit words (power of two)
SENTINEL, 32'hFFFF_FFFF, end-of-program marker word; never written to memory
TIMEOUT_CYCLES, 100000, maximum clk cycles between bytes of a partially received word

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte
rx_data  input  8  received byte
run_finished  input  1  core reports program end (level)
fetch_enable  output  1  core fetch/pipeline allowed to advance (RUN only)
run_flag  output  1  core released, program running
program_mem_write_enable  output  1  one-cycle write strobe
program_mem_write_data  output  32  assembled word
uart_write_address  output  32  byte address of current write (word_idx*4)
load_word_count  output  $clog2(MEM_WORDS)+1  words written in the last load
load_error  output  1  sticky error flag
state_o  output  3  current FSM state, for the monitor

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; byte index 0; word index 0; timeout counter 0.
- FSM encoding: IDLE=0, LOAD=1, RUN=2, DONE=3, ERROR=4.
- IDLE: the first rx_valid moves to LOAD. That byte is captured as byte 0.
- LOAD:
  - Bytes fill lanes [7:0], [15:8], [23:16], [31:24] in that order.
  - On the 4th byte the word is compared with SENTINEL in the same cycle.
  - Non-sentinel word: next cycle, program_mem_write_enable=1 for exactly 1 cycle, with program_mem_write_data=word and uart_write_address=word_idx<<2. word_idx then increments and the byte index resets to 0.
  - Sentinel word: nothing is written. Next cycle load_word_count=word_idx, run_flag=1, fetch_enable=1, and the state moves to RUN.
  - Write to word_idx==MEM_WORDS (memory full), non-sentinel: no write, go to ERROR.
  - Timeout counter: counts while the byte index is non-zero and resets on every rx_valid. Reaching TIMEOUT_CYCLES discards the partial word and goes to ERROR.
  - Sentinel received with word_idx==0: empty program. Go to ERROR.
- RUN:
  - run_flag=1 and fetch_enable=1.
  - rx_valid is ignored.
  - A rising edge of run_finished: on the next cycle run_flag=0, fetch_enable=0, state DONE.
- DONE:
  - Outputs hold 0 except load_word_count.
  - rx_valid starts a reload: word_idx=0, byte index=0, that byte is captured as byte 0, state LOAD.
- ERROR:
  - load_error=1; run_flag=0; fetch_enable=0.
  - Sticky; only reset_n leaves this state.
- rx_valid in the same cycle as a pending write: the byte is accepted. Writes are single-cycle, so there is never backpressure.
- reset_n asserted mid-load or mid-run: immediate return to the reset values. Memory contents are untouched.
- Widths: word_idx has $clog2(MEM_WORDS)+1 bits and never wraps. uart_write_address is zero-extended to 32 bits.

Optional Feature:
PROG_LOAD_CHECKSUM_EN
- Defined:
  - After the sentinel, 4 more bytes form a checksum word.
  - Required checksum = modulo 2^32 sum of all written words.
  - Match: RUN, one cycle after the last checksum byte.
  - Mismatch: ERROR.
  - The timeout rule also applies to checksum bytes.
- Undefined: the sentinel goes straight to RUN as specified above, and bytes after the sentinel are ignored.

Test Plan:
- Load 2 words, then sentinel:
  - Stimulus: bytes 13 00 00 00, B7 10 00 00, FF FF FF FF.
  - Writes: 32'h00000013 at address 0, then 32'h000010B7 at address 4.
  - Then load_word_count=2, run_flag=1 one cycle after the last FF.
  - No write for the sentinel.
- Run completion and reload:
  - From RUN, pulse run_finished → run_flag=0 next cycle, state DONE.
  - New bytes 93 00 10 00 → write 32'h00100093 at address 0.
- Timeout:
  - Send 2 bytes, then idle for TIMEOUT_CYCLES (set to 50).
  - Expect ERROR, load_error=1, no write.
  - Later bytes are ignored until reset_n.
- Overflow with MEM_WORDS=4:
  - Send 5 non-sentinel words.
  - 4 writes at addresses 0, 4, 8, 12; the 5th word goes to ERROR with no write.
- Reset mid-load:
  - Assert reset_n low after 6 bytes.
  - All outputs 0; the next 4 bytes write to address 0.
- PROG_LOAD_CHECKSUM_EN:
  - Words 1 and 2, sentinel, checksum 03 00 00 00 → RUN.
  - Same sequence with checksum 04 00 00 00 → ERROR.
